hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that produces the 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
- Sits beside EXE and stalls EXE while an operation is in flight.
- Delivers the result through a valid/ready handshake; downstream carries it to WB as hi_write/lo_write data (HI in the mem_result field, LO in the lo_result field).
- Aborts on the WB cancel signal (exception/eret flush) so flushed operations never write HI/LO.

Parameters:
- BITS_PER_CYCLE, 1: quotient/multiplier bits retired per iteration cycle. Legal values are 1, 2 and 4. Iteration count N = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- op_valid  in  1  EXE presents an operation
- op_type  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src1  in  32  rs value: multiplicand or dividend
- src2  in  32  rt value: multiplier or divisor
- op_ready  out  1  unit can accept; equals (state==IDLE)
- busy  out  1  operation accepted and not yet handed off; EXE stall
- cancel  in  1  flush from WB; kills any in-flight or pending result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_hi  out  32  MULT: product[63:32]; DIV: remainder
- res_lo  out  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE; op_ready=1; busy=0; res_valid=0; res_hi=0; res_lo=0.
  - Iteration counter and internal regs cleared.
  - Reset mid-operation discards the operation; no res_valid ever follows it.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - Accept when op_valid & op_ready & !cancel.
  - At acceptance, latch op_type and operand magnitudes. Signed ops (MULT, DIV) take abs values. Record result sign = sign(src1)^sign(src2) and remainder sign = sign(src1).
  - Go to CALC with counter=0.
- CALC, multiply:
  - Shift-add on the 64-bit accumulator, BITS_PER_CYCLE multiplier bits per cycle.
- CALC, divide:
  - Restoring division, BITS_PER_CYCLE quotient bits per cycle, 33-bit trial subtract.
- CALC exit: leave when counter==N-1, going to FIX.
- FIX (one cycle):
  - Apply sign correction for signed ops. Product: two's-complement negate the 64-bit value if the sign is set. Quotient negated if result sign set. Remainder negated if remainder sign set.
  - Load res_hi/res_lo, then go to DONE.
- DONE:
  - res_valid=1; res_hi/res_lo held stable.
  - On res_valid & res_ready, go to IDLE next cycle.
- Latency: acceptance cycle = cycle 0; CALC occupies cycles 1..N; FIX is cycle N+1; res_valid first high in cycle N+2. This is 34 cycles for BITS_PER_CYCLE=1 and 10 cycles for 4.
- busy: 1 from the cycle after acceptance through the cycle of the res handshake; 0 in IDLE.
- op_ready: 0 in CALC/FIX/DONE. No back-to-back acceptance in the handshake cycle; the next op is accepted at the earliest one cycle later.
- cancel:
  - Asserted in any state, it forces IDLE at the next edge, with res_valid=0 and busy=0 next cycle. res_hi/res_lo keep their last values.
  - cancel in the same cycle as op_valid in IDLE: no acceptance.
  - cancel in the same cycle as res_valid&res_ready: handoff still counts, state goes to IDLE; downstream owns suppression of the flushed write.
- Divide by zero:
  - Not an exception; runs the full latency.
  - Result is res_lo=32'hFFFFFFFF, res_hi=src1 for all divide variants. Sign fix is not applied.
- Overflow cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives res_lo=0x80000000, res_hi=0.
  - MULT 0x80000000 * 0x80000000 gives {hi,lo}=0x40000000_00000000.
- Operand inputs are don't-care outside the acceptance cycle.
- res_valid stays high with res_ready low indefinitely; outputs do not change.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, res_ready=1 -> res_valid in cycle 34 with res_hi=0xFFFFFFFE, res_lo=0x00000001; busy high cycles 1..34.
- MULT 0xFFFFFFFD(-3)*7 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFEB; then DIV -7/2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
- DIVU 100/0 -> res_lo=0xFFFFFFFF, res_hi=100. DIV 0x80000000/0xFFFFFFFF -> res_lo=0x80000000, res_hi=0.
- res_ready held low 10 cycles after res_valid -> res_valid and data stable throughout; op_valid ignored (op_ready=0); the op is accepted one cycle after the handshake.
- cancel pulsed at cycle 5 of DIVU -> IDLE/op_ready=1 at cycle 6, res_valid never asserts. cancel coincident with op_valid in IDLE -> no acceptance.
- BITS_PER_CYCLE=4, MULTU 0x12345678*0x9ABCDEF0 -> res_valid in cycle 10, {hi,lo}=0x0B00EA4E_242D2080. resetn low at cycle 4 -> all outputs at reset values, no result.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// Operation/result handshake between EXE and the HI/LO multiply-divide sequencer.
// The master side is EXE and downstream WB. The slave side is the sequencer.
interface hilo_muldiv_ctrl_if;
   logic        op_valid;
   logic [1:0]  op_type;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        op_ready;
   logic        busy;
   logic        cancel;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   modport master (
      output op_valid, op_type, src1, src2, cancel, res_ready,
      input  op_ready, busy, res_valid, res_hi, res_lo
   );

   modport slave (
      input  op_valid, op_type, src1, src2, cancel, res_ready,
      output op_ready, busy, res_valid, res_hi, res_lo
   );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing {HI,LO}.
// It works on operand magnitudes and applies the sign in a single fix-up cycle.
// A WB flush (cancel) returns the unit to idle from any state.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | op_ready high; accepts an op when op_valid and not cancel
// CALC   | N iterations, BITS_PER_CYCLE bits retired per cycle
// FIX    | sign correction; res_hi/res_lo loaded
// DONE   | res_valid held until res_ready
module hilo_muldiv_ctrl #(
   parameter int BITS_PER_CYCLE = 1
) (
   input logic               clk,
   input logic               resetn,
   hilo_muldiv_ctrl_if.slave bus
);
   localparam int B = BITS_PER_CYCLE;
   localparam int N = 32 / BITS_PER_CYCLE;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic        is_div_q;
   logic        res_sign_q;
   logic        rem_sign_q;
   logic        div_zero_q;
   // Multiply: {partial product, remaining multiplier}.
   // Divide: {partial remainder, dividend shifting into quotient}.
   logic [63:0] acc_q;
   // Operand that stays fixed: the multiplicand, or the divisor.
   logic [31:0] opnd_q;
   logic        op_ready_q;
   logic        busy_q;
   logic        res_valid_q;
   logic [31:0] res_hi_q;
   logic [31:0] res_lo_q;

   logic        in_signed;
   logic [31:0] src1_mag;
   logic [31:0] src2_mag;
   logic [3:0]  mul_dig;
   logic [35:0] mul_sum;
   logic [63:0] mul_next_d;
   logic [63:0] div_next_d;
   logic [32:0] rem33;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Operand magnitudes taken at acceptance. MULT and DIV are signed; MULTU and DIVU are unsigned.
   always_comb begin
      in_signed = ~bus.op_type[0];
      src1_mag  = (in_signed && bus.src1[31]) ? (~bus.src1 + 32'd1) : bus.src1;
      src2_mag  = (in_signed && bus.src2[31]) ? (~bus.src2 + 32'd1) : bus.src2;
   end

   // One multiply step: add multiplicand*digit into the upper half, then shift B bits right.
   always_comb begin
      mul_dig          = '0;
      mul_dig[B-1:0]   = acc_q[B-1:0];
      mul_sum          = {4'b0, acc_q[63:32]} + ({4'b0, opnd_q} * {32'b0, mul_dig});
      mul_next_d       = 64'({mul_sum, acc_q[31:0]} >> B);
   end

   // One divide step: B restoring iterations, each a 33-bit trial subtract.
   always_comb begin
      rem   = acc_q[63:32];
      quo   = acc_q[31:0];
      rem33 = '0;
      for (int i = 0; i < B; i++) begin
         rem33 = {rem, quo[31]};
         quo   = {quo[30:0], 1'b0};
         if (rem33 >= {1'b0, opnd_q}) begin
            rem    = 32'(rem33 - {1'b0, opnd_q});
            quo[0] = 1'b1;
         end else begin
            rem = rem33[31:0];
         end
      end
      div_next_d = {rem, quo};
   end

   // Sign fix-up. On divide-by-zero the quotient is forced to all ones.
   // The remainder still holds |src1|, and re-applying src1's sign returns src1 itself.
   always_comb begin
      prod_fix = res_sign_q ? (~acc_q + 64'd1) : acc_q;
      quo_fix  = div_zero_q ? 32'hFFFF_FFFF
               : (res_sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
      rem_fix  = rem_sign_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
   end

   // Sequencer state, datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         res_sign_q  <= 1'b0;
         rem_sign_q  <= 1'b0;
         div_zero_q  <= 1'b0;
         acc_q       <= '0;
         opnd_q      <= '0;
         op_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
      end else if (bus.cancel) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.op_valid) begin
                  state_q    <= S_CALC;
                  cnt_q      <= '0;
                  is_div_q   <= bus.op_type[1];
                  res_sign_q <= in_signed & (bus.src1[31] ^ bus.src2[31]);
                  rem_sign_q <= in_signed & bus.src1[31];
                  div_zero_q <= bus.op_type[1] & (bus.src2 == 32'd0);
                  if (bus.op_type[1]) begin
                     acc_q  <= {32'd0, src1_mag};
                     opnd_q <= src2_mag;
                  end else begin
                     acc_q  <= {32'd0, src2_mag};
                     opnd_q <= src1_mag;
                  end
                  op_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_CALC: begin
               acc_q <= is_div_q ? div_next_d : mul_next_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(N - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               if (is_div_q) begin
                  res_hi_q <= rem_fix;
                  res_lo_q <= quo_fix;
               end else begin
                  res_hi_q <= prod_fix[63:32];
                  res_lo_q <= prod_fix[31:0];
               end
               res_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  op_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               op_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.op_ready  = op_ready_q;
   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.res_lo    = res_lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl. It instantiates one copy with 1 bit per cycle and one with 4 bits per cycle.
// Results are predicted with plain 64-bit integer arithmetic.
module tb_hilo_muldiv_ctrl;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   hilo_muldiv_ctrl_if if1 ();
   hilo_muldiv_ctrl_if if4 ();

   hilo_muldiv_ctrl #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
   hilo_muldiv_ctrl #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4));

   logic        sel4;
   logic        op_valid_s, cancel_s, res_ready_s;
   logic [1:0]  op_type_s;
   logic [31:0] src1_s, src2_s;

   assign if1.op_valid  = op_valid_s & ~sel4;
   assign if4.op_valid  = op_valid_s & sel4;
   assign if1.op_type   = op_type_s;
   assign if4.op_type   = op_type_s;
   assign if1.src1      = src1_s;
   assign if4.src1      = src1_s;
   assign if1.src2      = src2_s;
   assign if4.src2      = src2_s;
   assign if1.cancel    = cancel_s;
   assign if4.cancel    = cancel_s;
   assign if1.res_ready = res_ready_s & ~sel4;
   assign if4.res_ready = res_ready_s & sel4;

   logic        rv, rdy, bsy;
   logic [31:0] rhi, rlo;
   always_comb begin
      rv  = sel4 ? if4.res_valid : if1.res_valid;
      rdy = sel4 ? if4.op_ready  : if1.op_ready;
      bsy = sel4 ? if4.busy      : if1.busy;
      rhi = sel4 ? if4.res_hi    : if1.res_hi;
      rlo = sel4 ? if4.res_lo    : if1.res_lo;
   end

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_res;

   function automatic logic [63:0] model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
      int     sa, sb, q, r;
      longint p;
      sa = a;
      sb = b;
      case (t)
         2'b00: begin p = longint'(sa) * longint'(sb); return p; end
         2'b01: return {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Present one op for one cycle. Returns at the falling edge inside cycle 1.
   task automatic issue(input logic s4, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
      sel4 = s4;
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL op_ready_before_issue got %b exp 1", rdy); end
      op_valid_s = 1'b1; op_type_s = t; src1_s = a; src2_s = b;
      @(negedge clk);
      op_valid_s = 1'b0; op_type_s = 2'($urandom); src1_s = $urandom; src2_s = $urandom;
   endtask

   // Wait from cycle 1 for res_valid. Checks busy on every cycle, then the latency and the data.
   task automatic wait_check(input logic [63:0] exp, input int lim);
      int lat;
      lat = 1;
      while (rv !== 1'b1 && lat < 100) begin
         checks++;
         if (bsy !== 1'b1 || rdy !== 1'b0) begin
            errors++; $display("FAIL busy_in_flight cycle %0d busy %b op_ready %b exp 1/0", lat, bsy, rdy);
         end
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== lim) begin errors++; $display("FAIL latency got %0d exp %0d", lat, lim); end
      checks++;
      if ({rhi, rlo} !== exp) begin errors++; $display("FAIL result got %h exp %h", {rhi, rlo}, exp); end
   endtask

   // Hold res_ready low for a few random cycles, then complete the handoff.
   task automatic handshake(input logic [63:0] exp);
      int hold;
      hold = $urandom_range(0, 3);
      repeat (hold) begin
         @(negedge clk);
         checks++;
         if (rv !== 1'b1 || {rhi, rlo} !== exp) begin
            errors++; $display("FAIL hold_stable rv %b data %h exp 1 %h", rv, {rhi, rlo}, exp);
         end
      end
      res_ready_s = 1'b1;
      checks++;
      if (bsy !== 1'b1) begin errors++; $display("FAIL busy_at_handshake got %b exp 1", bsy); end
      @(negedge clk);
      res_ready_s = 1'b0;
      checks++;
      if (rv !== 1'b0 || bsy !== 1'b0 || rdy !== 1'b1) begin
         errors++; $display("FAIL after_handshake rv %b busy %b op_ready %b exp 0/0/1", rv, bsy, rdy);
      end
      last_res = exp;
   endtask

   task automatic run_op(input logic s4, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      exp = model(t, a, b);
      issue(s4, t, a, b);
      wait_check(exp, s4 ? 10 : 34);
      handshake(exp);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (if1.op_ready !== 1'b1 || if1.busy !== 1'b0 || if1.res_valid !== 1'b0 || if1.res_hi !== 32'd0 || if1.res_lo !== 32'd0) begin
         errors++; $display("FAIL reset_dut1 rdy %b busy %b rv %b hi %h lo %h exp 1 0 0 0 0", if1.op_ready, if1.busy, if1.res_valid, if1.res_hi, if1.res_lo);
      end
      checks++;
      if (if4.op_ready !== 1'b1 || if4.busy !== 1'b0 || if4.res_valid !== 1'b0 || if4.res_hi !== 32'd0 || if4.res_lo !== 32'd0) begin
         errors++; $display("FAIL reset_dut4 rdy %b busy %b rv %b hi %h lo %h exp 1 0 0 0 0", if4.op_ready, if4.busy, if4.res_valid, if4.res_hi, if4.res_lo);
      end
      resetn = 1'b1;
      last_res = '0;
   endtask

   task automatic test_directed;
      run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7);
      run_op(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b0, 2'b11, 32'd100, 32'd0);
      run_op(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b0, 2'b00, 32'h8000_0000, 32'h8000_0000);
      run_op(1'b0, 2'b10, 32'hFFFF_FFF0, 32'd0);
      run_op(1'b0, 2'b10, 32'd7, 32'hFFFF_FFFE);
   endtask

   task automatic test_random(input logic s4, input int n);
      logic [31:0] a, b;
      logic [1:0]  t;
      for (int i = 0; i < n; i++) begin
         t = 2'($urandom);
         a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_op(s4, t, a, b);
      end
   endtask

   task automatic test_stall;
      logic [63:0] exp1, exp2;
      logic [31:0] a2, b2;
      exp1 = model(2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
      issue(1'b0, 2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
      wait_check(exp1, 34);
      a2 = $urandom; b2 = $urandom_range(1, 1000);
      exp2 = model(2'b11, a2, b2);
      op_valid_s = 1'b1; op_type_s = 2'b11; src1_s = a2; src2_s = b2;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (rv !== 1'b1 || rdy !== 1'b0 || {rhi, rlo} !== exp1) begin
            errors++; $display("FAIL stall_hold rv %b rdy %b data %h exp 1 0 %h", rv, rdy, {rhi, rlo}, exp1);
         end
      end
      res_ready_s = 1'b1;
      @(negedge clk);
      res_ready_s = 1'b0;
      checks++;
      if (rv !== 1'b0 || rdy !== 1'b1 || bsy !== 1'b0) begin
         errors++; $display("FAIL stall_no_b2b rv %b rdy %b busy %b exp 0 1 0", rv, rdy, bsy);
      end
      @(negedge clk);
      op_valid_s = 1'b0; src1_s = $urandom; src2_s = $urandom;
      checks++;
      if (bsy !== 1'b1 || rdy !== 1'b0) begin
         errors++; $display("FAIL stall_next_accept busy %b rdy %b exp 1 0", bsy, rdy);
      end
      wait_check(exp2, 34);
      handshake(exp2);
   endtask

   task automatic test_cancel;
      logic        seen;
      logic [63:0] exp;
      issue(1'b0, 2'b11, 32'd5000, 32'd7);
      repeat (4) @(negedge clk);
      cancel_s = 1'b1;
      @(negedge clk);
      cancel_s = 1'b0;
      checks++;
      if (rdy !== 1'b1 || bsy !== 1'b0 || rv !== 1'b0 || {rhi, rlo} !== last_res) begin
         errors++; $display("FAIL cancel_calc rdy %b busy %b rv %b data %h exp 1 0 0 %h", rdy, bsy, rv, {rhi, rlo}, last_res);
      end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (rv === 1'b1) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL cancel_no_result rv_seen %b exp 0", seen); end
      op_valid_s = 1'b1; cancel_s = 1'b1; op_type_s = 2'b01; src1_s = 32'd3; src2_s = 32'd4;
      @(negedge clk);
      op_valid_s = 1'b0; cancel_s = 1'b0;
      checks++;
      if (rdy !== 1'b1 || bsy !== 1'b0) begin
         errors++; $display("FAIL cancel_with_op_valid rdy %b busy %b exp 1 0", rdy, bsy);
      end
      exp = model(2'b00, 32'h0001_0001, 32'hFFFF_0003);
      issue(1'b0, 2'b00, 32'h0001_0001, 32'hFFFF_0003);
      wait_check(exp, 34);
      cancel_s = 1'b1;
      @(negedge clk);
      cancel_s = 1'b0;
      checks++;
      if (rv !== 1'b0 || bsy !== 1'b0 || rdy !== 1'b1 || {rhi, rlo} !== exp) begin
         errors++; $display("FAIL cancel_done rv %b busy %b rdy %b data %h exp 0 0 1 %h", rv, bsy, rdy, {rhi, rlo}, exp);
      end
      last_res = exp;
      exp = model(2'b10, 32'h7FFF_FFFF, 32'h0000_0010);
      issue(1'b0, 2'b10, 32'h7FFF_FFFF, 32'h0000_0010);
      wait_check(exp, 34);
      cancel_s = 1'b1; res_ready_s = 1'b1;
      @(negedge clk);
      cancel_s = 1'b0; res_ready_s = 1'b0;
      checks++;
      if (rv !== 1'b0 || rdy !== 1'b1) begin
         errors++; $display("FAIL cancel_with_handshake rv %b rdy %b exp 0 1", rv, rdy);
      end
      last_res = exp;
   endtask

   task automatic test_bpc4;
      run_op(1'b1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      run_op(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b1, 2'b11, 32'd100, 32'd0);
   endtask

   task automatic test_reset_mid;
      logic seen;
      issue(1'b1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1 || bsy !== 1'b0 || rv !== 1'b0 || rhi !== 32'd0 || rlo !== 32'd0) begin
         errors++; $display("FAIL reset_mid rdy %b busy %b rv %b hi %h lo %h exp 1 0 0 0 0", rdy, bsy, rv, rhi, rlo);
      end
      resetn = 1'b1;
      seen = 1'b0;
      repeat (20) begin @(negedge clk); if (rv === 1'b1) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_result rv_seen %b exp 0", seen); end
      last_res = '0;
   endtask

   initial begin
      sel4 = 1'b0; op_valid_s = 1'b0; cancel_s = 1'b0; res_ready_s = 1'b0;
      op_type_s = 2'b00; src1_s = '0; src2_s = '0; resetn = 1'b0; last_res = '0;
      test_reset;
      test_directed;
      test_stall;
      test_cancel;
      test_random(1'b0, 25);
      test_bpc4;
      test_random(1'b1, 25);
      test_reset_mid;
      run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
